key_repeat_ctrl: RTL

KEY_REPEAT_CTRL -- requirements
Module: key_repeat_ctrl

---
 rtl/key_repeat_ctrl_if.sv | 10 +
 rtl/key_repeat_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/key_repeat_ctrl_if.sv
// Key event bus: raw key level in; debounced level and press/release pulses out.
interface key_repeat_ctrl_if;
  logic key_i;
  logic held_o;
  logic press_o;
  logic release_o;

  modport master (output key_i, input held_o, press_o, release_o);
  modport slave  (input key_i, output held_o, press_o, release_o);
endinterface

// File: rtl/key_repeat_ctrl.sv
// Push-button conditioner: synchronize, debounce, then emit a press pulse
// followed by optional auto-repeat pulses while the key stays held.
module key_repeat_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  key_repeat_ctrl_if.slave  bus
);

  localparam int unsigned DW   = (DEBOUNCE_CYCLES >= 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = (TMAX >= 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);
  localparam bit            RPT_ON    = (REPEAT_EN != 0);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || REPEAT_EN > 1) begin : g_param_check
    $error("key_repeat_ctrl: counts must be >= 1 and REPEAT_EN must be 0 or 1");
  end

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic          sync_meta;
  logic          sync_q;
  logic [DW-1:0] deb_cnt_q;
  logic          held_q;
  logic          press_q;
  logic          release_q;
  logic [TW-1:0] timer_q;
  state_t        state_q;

  logic          press_d;
  logic          release_d;
  logic [TW-1:0] timer_d;
  state_t        state_d;

  logic differ_c;
  logic deb_done_c;
  logic rise_c;
  logic fall_c;
  logic dly_hit_c;
  logic rate_hit_c;

  assign differ_c   = (sync_q != held_q);
  assign deb_done_c = differ_c && (deb_cnt_q == DEB_LAST);
  assign rise_c     = deb_done_c && sync_q;
  assign fall_c     = deb_done_c && !sync_q;
  assign dly_hit_c  = RPT_ON && (timer_q == DLY_LAST);
  assign rate_hit_c = (timer_q == RATE_LAST);

  // Two-flop synchronizer for the asynchronous key level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= bus.key_i;
      sync_q    <= sync_meta;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_cnt_q <= '0;
      held_q    <= 1'b0;
    end else if (!differ_c) begin
      deb_cnt_q <= '0;
    end else if (deb_done_c) begin
      deb_cnt_q <= '0;
      held_q    <= sync_q;
    end else begin
      deb_cnt_q <= deb_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Debounced release dominates every state, so it also suppresses a coincident repeat.
  always_comb begin
    state_d = state_q;
    if (fall_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise_c)    state_d = DELAY;
        DELAY:   if (dly_hit_c) state_d = REPEAT;
        REPEAT:  state_d = REPEAT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    timer_d   = timer_q;
    if (fall_c) begin
      release_d = 1'b1;
      timer_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (rise_c) press_d = 1'b1;
        end
        DELAY: begin
          if (dly_hit_c) begin
            press_d = 1'b1;
            timer_d = '0;
          end else if (RPT_ON) begin
            timer_d = timer_q + TW'(1);
          end
        end
        REPEAT: begin
          if (rate_hit_c) begin
            press_d = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: timer_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      timer_q   <= timer_d;
    end
  end

  assign bus.held_o    = held_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;

endmodule
